reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
Parametrised successor to the decode-stage register file. It provides two registered read ports and one write port, all on a single posedge clock. It adds write-to-read bypass, an optional hardwired zero register, and a per-register pending-write scoreboard so decode can detect RAW hazards. It sits in the decode unit, with writeback driving the write port and issue driving the scoreboard set port.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, address width; depth = 2**ADDR_W registers
ZERO_REG, 1, if 1 then register 0 always reads 0, ignores writes and is never marked busy
BYPASS, 1, if 1 then a same-cycle write to the read address is forwarded to the read data

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
rd_en1  input  1  read port 1 enable
rd_addr1  input  ADDR_W  read port 1 address
rd_en2  input  1  read port 2 enable
rd_addr2  input  ADDR_W  read port 2 address
reg_wr  input  1  write enable (writeback)
reg_wr_addr  input  ADDR_W  write address
reg_wr_data  input  DATA_W  write data
busy_set  input  1  mark a destination register as pending (issue)
busy_set_addr  input  ADDR_W  register to mark pending
rd_data1  output  DATA_W  read port 1 data, registered
rd_data2  output  DATA_W  read port 2 data, registered
rd_busy1  output  1  port 1 register was pending at sample time, registered
rd_busy2  output  1  port 2 register was pending at sample time, registered
busy_vec  output  2**ADDR_W  current scoreboard flags, bit i = register i pending

Behaviour:
- Reset (reset=0, asynchronous, no clk needed):
  - all registers = 0; all busy flags = 0.
  - rd_data1/2 = 0, rd_busy1/2 = 0, busy_vec = 0.
  - Reset asserted mid-operation discards any in-flight write or set.
  - First state update after release occurs on the first posedge with reset=1.
- Write: on posedge, if reg_wr=1 then registers[reg_wr_addr] <= reg_wr_data. With ZERO_REG=1 and reg_wr_addr=0 the write is dropped.
- Read:
  - On posedge with rd_enN=1, rd_dataN <= value at rd_addrN and rd_busyN <= pending state. Latency is 1 cycle from address to data.
  - With rd_enN=0, rd_dataN and rd_busyN hold their values.
- Bypass:
  - With BYPASS=1, a read and a write to the same address in the same cycle makes rd_dataN = reg_wr_data.
  - With BYPASS=0 the read returns the old value.
  - ZERO_REG=1 with address 0 always reads 0, regardless of bypass.
- Scoreboard, per register, evaluated on posedge:
  - busy_set=1 sets flag[busy_set_addr].
  - reg_wr=1 clears flag[reg_wr_addr].
  - Set and clear on the same address in one cycle: set wins (new issue supersedes old writeback).
  - Register 0 is never set when ZERO_REG=1.
- rd_busyN sampling, on the same cycle as the read:
  - rd_busyN = (flag set OR same-cycle busy_set to that address) AND NOT (same-cycle reg_wr to that address with no same-cycle set).
  - When BYPASS=0, a same-cycle clear does not mask busy; rd_busyN uses the pre-edge flag OR set.
- busy_vec reflects the flags after the edge; no combinational path from inputs.
- Both read ports are independent; they may read the same address, and either may match the write address.
- Out-of-range addresses cannot occur, since depth is a power of two.

Test Plan:
1. Reset: hold reset=0 with random inputs toggling -> all outputs 0. Release, then read addr 7 on both ports -> rd_data1=rd_data2=0 and rd_busy=0 one cycle later.
2. Basic write/read: write 0xDEADBEEF to r5 in cycle n; read r5 in cycle n+1 -> rd_data1=0xDEADBEEF in cycle n+2. With rd_en1=0 afterwards and r5 rewritten, rd_data1 holds 0xDEADBEEF.
3. Bypass: in one cycle, write 0x12345678 to r9 and read r9 on port 2 -> rd_data2=0x12345678 next cycle. Rebuild with BYPASS=0 -> old value 0.
4. Zero register: write 0xFFFFFFFF to r0, busy_set r0, read r0 -> rd_data=0, rd_busy=0, busy_vec[0]=0. With ZERO_REG=0 -> 0xFFFFFFFF returned.
5. Scoreboard:
   - busy_set r3 -> busy_vec[3]=1; reading r3 gives rd_busy1=1.
   - reg_wr r3 together with read r3 -> rd_busy1=0 and data forwarded.
   - busy_set r3 and reg_wr r3 in the same cycle -> busy_vec[3]=1.
6. Mid-operation reset: busy_set r4 and reg_wr r4=0xAA, with reset asserted between edges -> busy_vec=0 and r4 reads 0 after release.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: decode-stage register file with two registered read ports,
// one write port, optional write-to-read bypass, optional hardwired zero
// register and a per-register pending-write scoreboard for RAW detection.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en1,
  input  logic [ADDR_W-1:0]      rd_addr1,
  input  logic                   rd_en2,
  input  logic [ADDR_W-1:0]      rd_addr2,
  input  logic                   reg_wr,
  input  logic [ADDR_W-1:0]      reg_wr_addr,
  input  logic [DATA_W-1:0]      reg_wr_data,
  input  logic                   busy_set,
  input  logic [ADDR_W-1:0]      busy_set_addr,
  output logic [DATA_W-1:0]      rd_data1,
  output logic [DATA_W-1:0]      rd_data2,
  output logic                   rd_busy1,
  output logic                   rd_busy2,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              wr_ok;
  logic              set_ok;

  // Writes and sets aimed at a hardwired zero register are dropped up front,
  // so neither the array nor the scoreboard ever sees them.
  assign wr_ok  = reg_wr && !(ZERO_REG && (reg_wr_addr == '0));
  assign set_ok = busy_set && !(ZERO_REG && (busy_set_addr == '0));

  // Register array update; reset clears every entry and discards a pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[reg_wr_addr] <= reg_wr_data;
    end
  end

  // Per-register scoreboard next state: a new issue (set) supersedes a
  // writeback (clear) landing on the same register in the same cycle.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
      assign busy_d[gi] = (set_ok && (busy_set_addr == ADDR_W'(gi))) ? 1'b1 :
                          (reg_wr && (reg_wr_addr == ADDR_W'(gi)))  ? 1'b0 :
                          busy_q[gi];
    end
  endgenerate

  // Scoreboard flags register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  // Two identical, independent read ports.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic              en;
      logic [ADDR_W-1:0] addr;
      logic              hit_wr;
      logic              hit_set;
      logic [DATA_W-1:0] rd_data_d;
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_busy_d;
      logic              rd_busy_q;

      assign en   = (gi == 0) ? rd_en1 : rd_en2;
      assign addr = (gi == 0) ? rd_addr1 : rd_addr2;

      // Read value and pending state as seen at this edge, including
      // same-cycle writeback/issue activity on the addressed register.
      always_comb begin
        hit_wr    = reg_wr && (reg_wr_addr == addr);
        hit_set   = set_ok && (busy_set_addr == addr);
        rd_data_d = regs_q[addr];
        if (BYPASS && wr_ok && hit_wr) begin
          rd_data_d = reg_wr_data;
        end
        if (ZERO_REG && (addr == '0)) begin
          rd_data_d = '0;
        end
        rd_busy_d = busy_q[addr] | hit_set;
        if (BYPASS && hit_wr && !hit_set) begin
          rd_busy_d = 1'b0;
        end
      end

      // Output registers update only when the port is enabled, otherwise hold.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          rd_data_q <= '0;
          rd_busy_q <= 1'b0;
        end else if (en) begin
          rd_data_q <= rd_data_d;
          rd_busy_q <= rd_busy_d;
        end
      end
    end
  endgenerate

  assign rd_data1 = g_rd[0].rd_data_q;
  assign rd_busy1 = g_rd[0].rd_busy_q;
  assign rd_data2 = g_rd[1].rd_data_q;
  assign rd_busy2 = g_rd[1].rd_busy_q;

endmodule
